// File: rtl/set_bit_iterator_pkg.sv
// set_bit_iter_pkg
// Shared definitions for the set-bit iterator and its zero-counter sub-block:
//   - state_e     : two-state control FSM encoding (IDLE / BUSY)
//   - idx_width() : index width for a given mask width (minimum 1 bit)
package set_bit_iter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // A 1-bit mask still needs a 1-bit index port.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/set_bit_iterator_tlz.sv
// set_bit_iterator_tlz
// Combinational trailing/leading-zero counter.
//   MODE=0 : o_cnt = number of zeros below the lowest set bit (trailing zeros)
//   MODE=1 : o_cnt = number of zeros above the highest set bit (leading zeros)
// Ports:
//   i_vec   [WIDTH-1:0] in  : vector to scan
//   o_cnt   [IDX_W-1:0] out : zero count, meaningful only when o_empty=0
//   o_empty             out : i_vec has no set bit
module set_bit_iterator_tlz
  import set_bit_iter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit MODE  = 1'b0,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_empty
);

  always_comb begin
    o_cnt   = '0;
    o_empty = (i_vec == '0);
    if (MODE == 1'b0) begin
      // Scan downwards so the lowest set bit is the last to write o_cnt.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_vec[i]) o_cnt = IDX_W'(i);
      end
    end else begin
      // Scan upwards so the highest set bit is the last to write o_cnt.
      for (int i = 0; i < WIDTH; i++) begin
        if (i_vec[i]) o_cnt = IDX_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/set_bit_iterator.sv
// set_bit_iterator
// Streaming multi-hit priority encoder: accepts a WIDTH-bit mask and emits the
// index of every set bit, one beat per output handshake, LSB-first (MODE=0)
// or MSB-first (MODE=1).
// Ports:
//   clk_i, rst_ni (sync, active-low), flush_i (sync abort of current mask)
//   in_valid_i / in_ready_o / in_mask_i   : mask input channel
//   out_valid_o / out_ready_i             : index output channel
//   out_idx_o   : bit index of current hit, counted from bit 0
//   out_last_o  : final beat of this mask
//   out_zero_o  : beat stands for an all-zero mask (ZERO_BEAT=1 only)
//   out_seq_o   : ordinal of this beat within its mask
//   dbg_state_o : current FSM state
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. Once out_valid_o rises, the beat fields
// stay stable until accepted (or until flush/reset). in_ready_o does not
// depend on in_valid_i; in_mask_i is only sampled on an input transfer.
module set_bit_iterator
  import set_bit_iter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MODE      = 1'b0,
  parameter bit ZERO_BEAT = 1'b0,
  parameter int IDX_W     = idx_width(WIDTH),
  parameter int SEQ_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_mask_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             out_zero_o,
  output logic [SEQ_W-1:0] out_seq_o,
  output state_e           dbg_state_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_mask;
  logic [SEQ_W-1:0] r_seq;
  logic             r_zero;

  // ---------------------------------------------------------------------------
  // Hit selection
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_cnt;
  logic             w_empty;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_onehot;
  logic             w_last;

  set_bit_iterator_tlz #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .IDX_W (IDX_W)
  ) u_tlz (
    .i_vec   (r_mask),
    .o_cnt   (w_cnt),
    .o_empty (w_empty)
  );

  // Leading-zero count measures from the top, so convert back to a bit index.
  assign w_idx    = (MODE == 1'b0) ? w_cnt : (IDX_W'(WIDTH - 1) - w_cnt);
  assign w_onehot = WIDTH'(1) << w_idx;
  // At most one bit left means this beat drains the mask.
  assign w_last   = r_zero || ((r_mask & (r_mask - WIDTH'(1))) == '0);

  // ---------------------------------------------------------------------------
  // Handshake terms
  // ---------------------------------------------------------------------------
  logic w_out_valid;
  logic w_in_ready;
  logic w_hs;
  logic w_accept;
  logic w_load_busy;

  assign w_out_valid = rst_ni && (r_state == ST_BUSY);
  assign w_hs        = w_out_valid && out_ready_i;
  // Ready while idle, or while the final beat leaves, so masks stream with no
  // bubble. Flush and reset both block acceptance in their cycle.
  assign w_in_ready  = rst_ni && !flush_i &&
                       ((r_state == ST_IDLE) || (w_hs && w_last));
  assign w_accept    = in_valid_i && w_in_ready;
  // An all-zero mask only produces a beat when ZERO_BEAT is set.
  assign w_load_busy = (in_mask_i != '0) || ZERO_BEAT;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (flush beats accept beats output handshake)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_state_nxt = w_load_busy ? ST_BUSY : ST_IDLE;
    end else if (w_hs && w_last) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all forced to idle values while rst_ni is low)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_zero_o  = 1'b0;
    out_idx_o   = '0;
    out_seq_o   = '0;
    in_ready_o  = w_in_ready;
    if (w_out_valid) begin
      out_valid_o = 1'b1;
      out_last_o  = w_last;
      out_zero_o  = r_zero;
      out_idx_o   = r_zero ? '0 : w_idx;
      out_seq_o   = r_seq;
    end
  end

  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------------------
  // Datapath: mask, beat counter, zero flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mask <= '0;
      r_seq  <= '0;
      r_zero <= 1'b0;
    end else if (flush_i) begin
      r_mask <= '0;
      r_seq  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      // Also covers a back-to-back load in the last-beat cycle.
      r_mask <= in_mask_i;
      r_seq  <= '0;
      r_zero <= ZERO_BEAT && (in_mask_i == '0);
    end else if (w_hs) begin
      if (w_last) begin
        r_mask <= '0;
        r_seq  <= '0;
        r_zero <= 1'b0;
      end else begin
        r_mask <= r_mask & ~w_onehot;
        r_seq  <= r_seq + SEQ_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Consistency: BUSY with a real mask must have a hit; IDLE holds no bits.
  // ---------------------------------------------------------------------------
  a_busy_has_hit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((r_state == ST_BUSY) && !r_zero) |-> !w_empty);
  a_idle_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_IDLE) |-> w_empty);
  a_zero_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_zero |-> w_empty);

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb_set_bit_iterator
// Two instances at WIDTH=8: dut 0 is MODE=0/ZERO_BEAT=1, dut 1 is
// MODE=1/ZERO_BEAT=0. Inputs change just after the falling edge and outputs
// are sampled 1 time unit later; transfers happen on the next rising edge.
module tb_set_bit_iterator;
  import set_bit_iter_pkg::*;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int SW = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          flush     [2];
  logic          in_valid  [2];
  logic          out_ready [2];
  logic [W-1:0]  in_mask   [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic          out_zero  [2];
  logic [IW-1:0] out_idx   [2];
  logic [SW-1:0] out_seq   [2];
  state_e        dbg       [2];

  set_bit_iterator #(.WIDTH(W), .MODE(1'b0), .ZERO_BEAT(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_mask_i(in_mask[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_idx_o(out_idx[0]),
    .out_last_o(out_last[0]), .out_zero_o(out_zero[0]), .out_seq_o(out_seq[0]),
    .dbg_state_o(dbg[0])
  );

  set_bit_iterator #(.WIDTH(W), .MODE(1'b1), .ZERO_BEAT(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_mask_i(in_mask[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_idx_o(out_idx[1]),
    .out_last_o(out_last[1]), .out_zero_o(out_zero[1]), .out_seq_o(out_seq[1]),
    .dbg_state_o(dbg[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: packed beat {idx[2:0], last, zero, seq[3:0]}
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list the set bits in priority order; each beat's ordinal is
  // its position in that list and only the final one is marked last.
  function automatic void build(input int d, input logic [W-1:0] m);
    int idxs[$];
    exp_q.delete();
    for (int k = 0; k < W; k++) begin
      int b;
      b = (d == 1) ? (W - 1 - k) : k;
      if (m[b]) idxs.push_back(b);
    end
    if (m == '0 && d == 0) begin
      exp_q.push_back({3'd0, 1'b1, 1'b1, 4'd0});
    end else begin
      for (int k = 0; k < idxs.size(); k++)
        exp_q.push_back({3'(idxs[k]), (k == idxs.size() - 1), 1'b0, 4'(k)});
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int d, input logic [W-1:0] m);
    in_mask[d]  = m;
    in_valid[d] = 1'b1;
    #1;
    chk("in_ready_accept", 32'(in_ready[d]), 32'd1);
    tick();
    in_valid[d] = 1'b0;
    in_mask[d]  = 8'($urandom);
  endtask

  // Consume up to max_beats beats, optionally stalling stall_n cycles on beat
  // stall_beat and/or randomising out_ready.
  task automatic drain(input int d, input int stall_beat, input int stall_n,
                       input bit rnd, input int max_beats);
    int beat   = 0;
    int stalls = 0;
    int budget = 200;
    logic [8:0] e;
    while (exp_q.size() > 0 && beat < max_beats && budget > 0) begin
      budget--;
      if (beat == stall_beat && stalls < stall_n) begin
        out_ready[d] = 1'b0;
        stalls++;
      end else begin
        out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      e = exp_q[0];
      chk("out_valid", 32'(out_valid[d]), 32'd1);
      chk("out_idx",   32'(out_idx[d]),   32'(e[8:6]));
      chk("out_last",  32'(out_last[d]),  32'(e[5]));
      chk("out_zero",  32'(out_zero[d]),  32'(e[4]));
      chk("out_seq",   32'(out_seq[d]),   32'(e[3:0]));
      if (out_ready[d]) begin
        void'(exp_q.pop_front());
        beat++;
      end
      tick();
    end
    out_ready[d] = 1'b1;
    chk("drain_budget", 32'(budget > 0), 32'd1);
  endtask

  task automatic check_idle(input int d);
    #1;
    chk("idle_out_valid", 32'(out_valid[d]), 32'd0);
    chk("idle_in_ready",  32'(in_ready[d]),  32'd1);
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
    chk("rst_in_ready",  32'(in_ready[d]),  32'd0);
    chk("rst_out_idx",   32'(out_idx[d]),   32'd0);
    chk("rst_out_seq",   32'(out_seq[d]),   32'd0);
    chk("rst_out_last",  32'(out_last[d]),  32'd0);
    chk("rst_out_zero",  32'(out_zero[d]),  32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] m;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1; in_mask[d] = '0;
    end
    @(negedge clk);
    tick();
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    chk("rst_state", 32'(dbg[0]), 32'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready0", 32'(in_ready[0]), 32'd1);
    chk("post_rst_in_ready1", 32'(in_ready[1]), 32'd1);
    @(negedge clk);

    // LSB-first, then MSB-first, full ready
    build(0, 8'b1010_0100); send(0, 8'b1010_0100); drain(0, -1, 0, 1'b0, 99); check_idle(0);
    @(negedge clk);
    build(1, 8'b1010_0100); send(1, 8'b1010_0100); drain(1, -1, 0, 1'b0, 99); check_idle(1);
    @(negedge clk);

    // Backpressure: three stall cycles on the second beat
    build(0, 8'b1010_0100); send(0, 8'b1010_0100); drain(0, 1, 3, 1'b0, 99); check_idle(0);
    @(negedge clk);

    // Back-to-back: 8'h01 then 8'h80 with in_valid held high
    in_mask[0] = 8'h01; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1; chk("b2b_ready0", 32'(in_ready[0]), 32'd1);
    tick();
    in_mask[0] = 8'h80;
    #1;
    chk("b2b_valid_a", 32'(out_valid[0]), 32'd1);
    chk("b2b_idx_a",   32'(out_idx[0]),   32'd0);
    chk("b2b_last_a",  32'(out_last[0]),  32'd1);
    chk("b2b_ready_a", 32'(in_ready[0]),  32'd1);
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("b2b_valid_b", 32'(out_valid[0]), 32'd1);
    chk("b2b_idx_b",   32'(out_idx[0]),   32'd7);
    chk("b2b_seq_b",   32'(out_seq[0]),   32'd0);
    chk("b2b_last_b",  32'(out_last[0]),  32'd1);
    tick();
    check_idle(0);
    @(negedge clk);

    // Zero masks: one zero beat (dut0) / silently dropped (dut1)
    build(0, 8'h00); send(0, 8'h00); drain(0, -1, 0, 1'b0, 99); check_idle(0);
    @(negedge clk);
    build(1, 8'h00); send(1, 8'h00); drain(1, -1, 0, 1'b0, 99); check_idle(1);
    @(negedge clk);

    // Flush after three beats of 8'hFF
    build(0, 8'hFF); send(0, 8'hFF); drain(0, -1, 0, 1'b0, 3);
    flush[0] = 1'b1; out_ready[0] = 1'b1;
    #1;
    chk("flush_in_ready",  32'(in_ready[0]),  32'd0);
    chk("flush_out_valid", 32'(out_valid[0]), 32'd1);
    chk("flush_out_idx",   32'(out_idx[0]),   32'd3);
    tick();
    flush[0] = 1'b0;
    check_idle(0);
    chk("flush_seq", 32'(out_seq[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("flush_no_beat", 32'(out_valid[0]), 32'd0);
    end
    @(negedge clk);

    // Reset in the middle of 8'hFF on the MSB-first instance
    build(1, 8'hFF); send(1, 8'hFF); drain(1, -1, 0, 1'b0, 3);
    rst_n = 1'b0;
    #1; check_reset_outputs(1);
    tick(); #1; check_reset_outputs(1);
    rst_n = 1'b1;
    check_idle(1);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk("rst_no_beat", 32'(out_valid[1]), 32'd0);
    end
    @(negedge clk);

    // All-ones on both instances, random ready
    build(0, 8'hFF); send(0, 8'hFF); drain(0, -1, 0, 1'b1, 99); check_idle(0);
    @(negedge clk);
    build(1, 8'hFF); send(1, 8'hFF); drain(1, -1, 0, 1'b1, 99); check_idle(1);
    @(negedge clk);

    // Random masks with random backpressure
    for (int i = 0; i < 40; i++) begin
      int d;
      d = i % 2;
      case ($urandom_range(0, 7))
        0:       m = 8'h00;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      build(d, m); send(d, m); drain(d, -1, 0, 1'b1, 99); check_idle(d);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/set_bit_iterator.md
Name: set_bit_iterator

Overview:
- Streaming multi-hit priority encoder. Accepts a WIDTH-bit request mask over a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order: LSB-first or MSB-first.
- Successor to the single-hit trailing/leading-zero counter: it generalises that block to all hits with handshaking and backpressure.
- Used by issue/wakeup and writeback logic to serialise bitmask events, e.g. ready-entry masks and pending-interrupt vectors.

Parameters:
- WIDTH, 16: mask width; must be ≥1.
- MODE, 1'b0: 0 emits the LSB first (trailing order); 1 emits the MSB first (leading order).
- ZERO_BEAT, 1'b0: 1 makes an all-zero mask produce one beat with out_zero_o=1; 0 silently drops an all-zero mask.
- IDX_W, (WIDTH>1)?$clog2(WIDTH):1: derived; index width.
- SEQ_W, $clog2(WIDTH+1): derived; beat-counter width.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: synchronous active-low reset.
- flush_i, in, 1: synchronous abort of the current mask.
- in_valid_i, in, 1: input mask valid.
- in_ready_o, out, 1: block can accept a mask.
- in_mask_i, in, WIDTH: request mask.
- out_valid_o, out, 1: an index beat is valid.
- out_ready_i, in, 1: consumer accepts the beat.
- out_idx_o, out, IDX_W: bit index of the current hit, counted from bit 0 regardless of MODE.
- out_last_o, out, 1: current beat is the final beat of this mask.
- out_zero_o, out, 1: beat represents an all-zero mask (ZERO_BEAT=1 only).
- out_seq_o, out, SEQ_W: ordinal of this beat within the mask, starting at 0.

Behaviour:
- Reset and clock: one clock, clk_i; synchronous active-low reset rst_ni.
- Reset values, held while rst_ni=0:
  - state IDLE, mask register 0, seq 0, zero flag 0.
  - out_valid_o=0, out_last_o=0, out_zero_o=0, out_idx_o=0, out_seq_o=0, in_ready_o=0.
  - in_ready_o goes to 1 in the first cycle with rst_ni=1.
- FSM has two states, IDLE and BUSY.
  - IDLE: in_ready_o=1 and out_valid_o=0.
  - Accept when in_valid_i&&in_ready_o:
    - Nonzero mask: load it and go to BUSY.
    - Zero mask with ZERO_BEAT=1: set the zero flag and go to BUSY.
    - Zero mask with ZERO_BEAT=0: stay in IDLE; no beat is produced.
  - BUSY: out_valid_o=1.
    - out_idx_o is the first set bit of the registered mask in MODE order.
    - out_last_o=1 iff (mask & (mask-1))==0, or the zero flag is set.
    - out_zero_o equals the zero flag; in that case out_idx_o=0.
  - On an output handshake (out_valid_o&&out_ready_i):
    - Clear the emitted bit and increment seq.
    - If the beat was last, go to IDLE and clear seq and the zero flag.
- Latency: a mask accepted at edge N gives its first beat valid in cycle N+1. A mask with k set bits needs k handshake cycles.
- Back-to-back: in_ready_o=1 also in BUSY when out_valid_o&&out_ready_i&&out_last_o. A mask accepted in that cycle loads directly, giving zero bubbles between masks.
- Backpressure: while out_ready_i=0, out_idx_o, out_last_o, out_seq_o and out_zero_o are held stable, and the mask is unchanged.
- flush_i=1:
  - Next state is IDLE; mask, seq and zero flag are cleared.
  - in_ready_o is forced to 0 in the flush cycle.
  - out_valid_o is unaffected in the flush cycle. A handshake in that cycle is still counted by the consumer, but the block's state is discarded.
- Reset while BUSY drops the mask with no further beats. Reset has priority over flush, and flush has priority over handshakes.
- WIDTH=1: IDX_W=1, out_idx_o is always 0, and every nonzero mask gives a single beat.
- All-ones mask: produces WIDTH beats, out_seq_o runs 0..WIDTH-1, and the final beat has out_last_o=1.
- Input rule: in_mask_i is sampled only on the input handshake; the block does not require it to be stable otherwise.

Decomposition:
- Shared package set_bit_iter_pkg:
  - state enum (IDLE, BUSY).
  - idx_width(WIDTH) helper function giving IDX_W.
- Sub-module: the existing trailing/leading-zero counter, instantiated once.
  - Driven with the registered mask, WIDTH and MODE.
  - Its count gives out_idx_o directly in MODE=0.
  - In MODE=1 the index is WIDTH-1-count.
  - Its empty output is cross-checked against state in assertions.
- Clearing the emitted bit uses a one-hot decode of out_idx_o: mask & ~(1<<idx).

Test Plan:
- WIDTH=8, MODE=0, mask 8'b1010_0100, out_ready_i=1 → idx 2,5,7; seq 0,1,2; out_last_o only on idx 7; out_valid_o first high one cycle after accept.
- Same mask with MODE=1 → idx 7,5,2; out_last_o on idx 2.
- Backpressure: same mask, out_ready_i low for 3 cycles on the second beat → idx 5 and seq 1 held stable for those cycles; no beat lost or duplicated.
- Back-to-back: mask 8'h01 then 8'h80, in_valid_i held high, out_ready_i=1 → beats idx 0 then 7 on consecutive cycles; in_ready_o high on the last-beat cycle.
- Zero mask:
  - ZERO_BEAT=1 → one beat with out_zero_o=1, out_last_o=1, out_idx_o=0.
  - ZERO_BEAT=0 → no beat, in_ready_o stays 1.
- Flush and reset:
  - Mask 8'hFF, flush_i asserted after 3 beats → IDLE next cycle, no further beats; in_ready_o=0 in the flush cycle, 1 after.
  - Repeat with rst_ni pulled low instead of flush_i → all outputs at their reset values.
